// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with valid/ready, flush, bubbles, stall counter; optional skid buffer via ID_EX_SKID_EN
module id_ex_pipe #(
  parameter int ALUOP_W = 8,
  parameter int ALUSEL_W = 3,
  parameter int REG_W = 32,
  parameter int RADDR_W = 5,
  parameter int NOP_ALUOP = 0,
  parameter int NOP_ALUSEL = 0,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [REG_W-1:0]    id_reg1,
  input  logic [REG_W-1:0]    id_reg2,
  input  logic [RADDR_W-1:0]  id_wd,
  input  logic                id_wreg,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [REG_W-1:0]    ex_reg1,
  output logic [REG_W-1:0]    ex_reg2,
  output logic [RADDR_W-1:0]  ex_wd,
  output logic                ex_wreg,
  output logic [CNT_W-1:0]    stall_cycles
);
  localparam int PW = ALUOP_W + ALUSEL_W + 2 * REG_W + RADDR_W + 1;
  logic [PW-1:0] in_p, ex_p, nop_p;
  logic free, acc;
  assign nop_p = {ALUOP_W'(NOP_ALUOP), ALUSEL_W'(NOP_ALUSEL), {(2 * REG_W + RADDR_W + 1){1'b0}}};
  assign in_p = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};
  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg} = ex_p;
  assign free = !ex_valid || ex_ready;
  assign acc = id_valid && id_ready;
`ifdef ID_EX_SKID_EN
  logic skid_full;
  logic [PW-1:0] skid_p;
  assign id_ready = !rst && !skid_full;
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_p <= nop_p;
      skid_full <= 1'b0;
      skid_p <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_p <= nop_p;
      skid_full <= 1'b0;
    end else if (free) begin
      ex_valid <= skid_full || acc;
      ex_p <= skid_full ? skid_p : acc ? in_p : nop_p;
      skid_full <= 1'b0;
    end else if (acc) begin
      skid_full <= 1'b1;
      skid_p <= in_p;
    end
  end
`else
  assign id_ready = !rst && free;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid <= 1'b0;
      ex_p <= nop_p;
    end else if (free) begin
      ex_valid <= acc;
      ex_p <= acc ? in_p : nop_p;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (ex_valid && !ex_ready && stall_cycles != {CNT_W{1'b1}})
      stall_cycles <= stall_cycles + 1'b1;
  end
endmodule
